// File: rtl/fsm_seq_driver_if.sv
// fsm_seq_driver_if: request/stimulus/status bundle between the sequencer and its environment
interface fsm_seq_driver_if;
   logic       start;
   logic       order;
   logic [1:0] expect_ca;
   logic [1:0] ca;
   logic       c1;
   logic       c2;
   logic       i;
   logic       busy;
   logic       done;
   logic       error;
   logic       dut_rst;
   modport master (
      output start, order, expect_ca, ca,
      input  c1, c2, i, busy, done, error, dut_rst
   );
   modport slave (
      input  start, order, expect_ca, ca,
      output c1, c2, i, busy, done, error, dut_rst
   );
endinterface

// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver: timed C1/C2/I stimulus sequencer with Ca check; SEQ_DRIVER_RETRY_EN adds one reset-and-rerun on timeout
module fsm_seq_driver #(
   parameter int GAP     = 2,
   parameter int TIMEOUT = 8
) (
   input logic clk,
   input logic reset,
   fsm_seq_driver_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, FIRST, GAP1, IDENT, GAP2, SECOND, WAIT, DONE, ERR
`ifdef SEQ_DRIVER_RETRY_EN
      , RETRY
`endif
   } state_t;
   localparam logic [7:0] GAP_END = 8'(GAP - 1);
   localparam logic [7:0] TO_END  = 8'(TIMEOUT - 1);
   state_t     state, state_n;
   logic [7:0] cnt;
   logic       ord;
   logic [1:0] exp_ca;
   logic       err;
   logic       accept;
   assign accept = state == IDLE && bus.start;
`ifdef SEQ_DRIVER_RETRY_EN
   logic retried;
   always_ff @(posedge clk or posedge reset)
      if (reset) retried <= 1'b0;
      else retried <= accept ? 1'b0 : (state_n == RETRY ? 1'b1 : retried);
`endif
   // cnt restarts on every state change so each timed state counts from 0
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ord    <= 1'b0;
         exp_ca <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= state_n == state ? cnt + 8'd1 : '0;
         if (accept) begin
            ord    <= bus.order;
            exp_ca <= bus.expect_ca;
         end
         err <= accept ? 1'b0 : (state_n == ERR ? 1'b1 : err);
      end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (bus.start) state_n = FIRST;
         FIRST:  state_n = GAP1;
         GAP1:   if (cnt == GAP_END) state_n = IDENT;
         IDENT:  state_n = GAP2;
         GAP2:   if (cnt == GAP_END) state_n = SECOND;
         SECOND: state_n = WAIT;
         WAIT:
            if (bus.ca == exp_ca) state_n = DONE;
`ifdef SEQ_DRIVER_RETRY_EN
            else if (cnt == TO_END) state_n = retried ? ERR : RETRY;
         RETRY:  if (cnt == 8'd1) state_n = FIRST;
`else
            else if (cnt == TO_END) state_n = ERR;
`endif
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      bus.c1    = (state == FIRST && !ord) || (state == SECOND && ord);
      bus.c2    = (state == FIRST && ord) || (state == SECOND && !ord);
      bus.i     = state == IDENT;
      bus.done  = state == DONE;
      bus.error = err;
`ifdef SEQ_DRIVER_RETRY_EN
      bus.busy    = state inside {FIRST, GAP1, IDENT, GAP2, SECOND, WAIT, RETRY};
      bus.dut_rst = state == RETRY;
`else
      bus.busy    = state inside {FIRST, GAP1, IDENT, GAP2, SECOND, WAIT};
      bus.dut_rst = 1'b0;
`endif
   end
endmodule

// File: tb/tb_fsm_seq_driver.sv
// tb_fsm_seq_driver: randomized runs against a per-cycle offset model of the sequence timeline
module tb_fsm_seq_driver;
   localparam int GAP     = 2;
   localparam int TIMEOUT = 8;
   localparam int WS      = 2 * GAP + 4;
   localparam int WE      = WS + TIMEOUT - 1;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   runs = 0;
   logic prev_err = 1'b0;
   fsm_seq_driver_if b ();
   fsm_seq_driver #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(b.slave));
   always #5 clk = ~clk;
   function automatic logic [6:0] outs();
      return {b.c1, b.c2, b.i, b.busy, b.done, b.error, b.dut_rst};
   endfunction
   // expected {c1,c2,i,busy,done,error,dut_rst} at cycle t after the start edge; m = match cycle or -1
   function automatic logic [6:0] model(int t, logic ord, int m, logic pe);
      int   fin = m >= 0 ? m + 1 : WE + 1;
      logic c1, c2, id, bs, dn, er;
      c1 = (t == 1 && !ord) || (t == 2 * GAP + 3 && ord);
      c2 = (t == 1 && ord) || (t == 2 * GAP + 3 && !ord);
      id = t == GAP + 2;
      bs = t >= 1 && t < fin;
      dn = m >= 0 && t == fin;
      er = t == 0 ? pe : (m < 0 && t >= fin);
      return {c1, c2, id, bs, dn, er, 1'b0};
   endfunction
   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("idle", outs(), {5'b0, prev_err, 1'b0});
         b.start = 1'b0;
         b.ca    = 2'($urandom);
      end
   endtask
   task automatic run(input logic ord, input logic [1:0] ex, input int m, input int rst_at);
      int fin = m >= 0 ? m + 1 : WE + 1;
      runs++;
      for (int t = 0; t <= fin; t++) begin
         @(negedge clk);
         check($sformatf("run%0d_t%0d", runs, t), outs(), model(t, ord, m, prev_err));
         if (t == rst_at) begin
            b.start = 1'b0;
            reset = 1'b1;
            #1 check("async_reset", outs(), 7'b0);
            @(negedge clk);
            check("held_reset", outs(), 7'b0);
            reset = 1'b0;
            prev_err = 1'b0;
            return;
         end
         b.start     = t == 0 ? 1'b1 : 1'($urandom);
         b.order     = t == 0 ? ord : 1'($urandom);
         b.expect_ca = t == 0 ? ex : 2'($urandom);
         if (t == m) b.ca = ex;
         else if (t >= WS && (m < 0 ? t <= WE : t < m)) b.ca = ex ^ 2'($urandom_range(1, 3));
         else b.ca = 2'($urandom);
      end
      prev_err = m < 0;
   endtask
   initial begin
      reset = 1'b1;
      b.start = 1'b0;
      b.order = 1'b0;
      b.expect_ca = 2'b0;
      b.ca = 2'b0;
      #1 check("reset_state", outs(), 7'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      run(1'b1, 2'b11, WS, -1);
      run(1'b0, 2'b01, WS, -1);
      idle(1);
      run(1'b0, 2'b11, -1, -1);
      idle(3);
      run(1'b1, 2'b10, WE, -1);
      run(1'b0, 2'b00, -1, -1);
      run(1'b1, 2'b11, -1, 5);
      idle(2);
      for (int r = 0; r < 40; r++) begin
         int kind = $urandom_range(0, 3);
         int m = kind == 0 ? WS : kind == 1 ? WE : kind == 2 ? int'($urandom_range(WS, WE)) : -1;
         int ra = $urandom_range(0, 7) == 0 ? int'($urandom_range(1, WE)) : -1;
         run(1'($urandom), 2'($urandom), m, ra);
         idle($urandom_range(0, 2));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
